freq_cmd_sequencer: RTL and testbench

- Fabric-side controller for the freq1 PIO pair.
- Accepts 32-bit command words written by the HPS, delivered on the PIO output to the fabric.
- Decodes and sequences them into tuning-word loads and enable/phase controls for the downstream NCO frequency generator.
- Returns a 4-bit status word to the HPS on the PIO input from the fabric, using a toggle-based handshake.

---
 rtl/freq_cmd_sequencer_if.sv | 38 +++
 rtl/freq_cmd_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_freq_cmd_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/freq_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : freq_cmd_sequencer_if
//  Description : HPS command/status PIO pair and NCO control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface freq_cmd_sequencer_if #(
    parameter int TW_WIDTH = 24
);
    logic [31:0]         cmd_word;
    logic [3:0]          status_word;
    logic [TW_WIDTH-1:0] nco_tw;
    logic                nco_tw_load;
    logic                gen_ready;
    logic                nco_enable;
    logic                nco_phase_clr;

    modport master (
        output cmd_word,
        output gen_ready,
        input  status_word,
        input  nco_tw,
        input  nco_tw_load,
        input  nco_enable,
        input  nco_phase_clr
    );

    modport slave (
        input  cmd_word,
        input  gen_ready,
        output status_word,
        output nco_tw,
        output nco_tw_load,
        output nco_enable,
        output nco_phase_clr
    );
endinterface
`default_nettype wire

// File: rtl/freq_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : freq_cmd_sequencer
//  Description : Decodes toggle-handshaked HPS command words into NCO tuning
//                word loads and enable/phase controls, returning status.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_cmd_sequencer #(
    parameter int TW_WIDTH      = 24,
    parameter int SETTLE_CYCLES = 16
) (
    input  wire logic           clk_clk,
    input  wire logic           reset_reset_n,
    freq_cmd_sequencer_if.slave bus
);

    localparam int c_CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] c_OP_NOP       = 3'd0;
    localparam logic [2:0] c_OP_SET_TW    = 3'd1;
    localparam logic [2:0] c_OP_START     = 3'd2;
    localparam logic [2:0] c_OP_STOP      = 3'd3;
    localparam logic [2:0] c_OP_COMMIT    = 3'd4;
    localparam logic [2:0] c_OP_PHASE_CLR = 3'd5;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_EXEC   = 3'd2,
        S_LOAD   = 3'd3,
        S_SETTLE = 3'd4,
        S_ACK    = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    // Reserved bits [27:24] are never stored.
    logic                r_cmd_q_tog;
    logic [2:0]          r_cmd_q_op;
    logic [23:0]         r_cmd_q_arg;

    logic                r_cmd_tog;
    logic [2:0]          r_cmd_op;
    logic [23:0]         r_cmd_arg;
    logic                r_cmd_err;

    logic                r_ack;
    logic                r_busy;
    logic                r_err;
    logic                r_nco_en;
    logic                r_nco_load;
    logic [TW_WIDTH-1:0] r_nco_tw;
    logic [TW_WIDTH-1:0] r_staged_tw;
    logic [TW_WIDTH-1:0] r_active_tw;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_arg_hi;
    logic                w_arg_bad;
    logic                w_exec_err;
    logic                w_phase_clr;

    // Left unreset so INIT baselines the ack against the toggle present during reset.
    always_ff @(posedge clk_clk) begin
        r_cmd_q_tog <= bus.cmd_word[31];
        r_cmd_q_op  <= bus.cmd_word[30:28];
        r_cmd_q_arg <= bus.cmd_word[23:0];
    end

    generate
        if (TW_WIDTH < 24) begin : g_arg_hi
            assign w_arg_hi = |r_cmd_arg[23:TW_WIDTH];
        end else begin : g_arg_full
            assign w_arg_hi = 1'b0;
        end
    endgenerate

    assign w_arg_bad = (r_cmd_arg == 24'd0) || w_arg_hi;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_exec_err   = 1'b0;
        w_phase_clr  = 1'b0;
        case (r_state)
            S_INIT: w_next_state = S_IDLE;
            S_IDLE: begin
                if (r_cmd_q_tog != r_ack) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = S_ACK;
                case (r_cmd_op)
                    c_OP_NOP:       w_exec_err = 1'b0;
                    c_OP_SET_TW:    w_exec_err = w_arg_bad;
                    c_OP_START:     w_exec_err = (r_active_tw == '0);
                    c_OP_STOP:      w_exec_err = 1'b0;
                    c_OP_COMMIT:    w_next_state = S_LOAD;
                    c_OP_PHASE_CLR: w_phase_clr = 1'b1;
                    default:        w_exec_err = 1'b1;
                endcase
            end
            S_LOAD: begin
                if (bus.gen_ready) begin
                    w_next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_next_state = S_ACK;
                end
            end
            S_ACK:   w_next_state = S_IDLE;
            default: w_next_state = S_INIT;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_cmd_tog   <= 1'b0;
            r_cmd_op    <= 3'd0;
            r_cmd_arg   <= 24'd0;
            r_cmd_err   <= 1'b0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_nco_en    <= 1'b0;
            r_nco_load  <= 1'b0;
            r_nco_tw    <= '0;
            r_staged_tw <= '0;
            r_active_tw <= '0;
            r_cnt       <= '0;
        end else begin
            r_busy <= (w_next_state == S_EXEC) || (w_next_state == S_LOAD) ||
                      (w_next_state == S_SETTLE) || (w_next_state == S_ACK);
            case (r_state)
                S_INIT: r_ack <= r_cmd_q_tog;
                S_IDLE: begin
                    // Freeze the command so later toggles cannot alter it mid-flight.
                    if (w_next_state == S_EXEC) begin
                        r_cmd_tog <= r_cmd_q_tog;
                        r_cmd_op  <= r_cmd_q_op;
                        r_cmd_arg <= r_cmd_q_arg;
                    end
                end
                S_EXEC: begin
                    r_cmd_err <= w_exec_err;
                    case (r_cmd_op)
                        c_OP_SET_TW: begin
                            if (!w_arg_bad) begin
                                r_staged_tw <= r_cmd_arg[TW_WIDTH-1:0];
                            end
                        end
                        c_OP_START: begin
                            if (r_active_tw != '0) begin
                                r_nco_en <= 1'b1;
                            end
                        end
                        c_OP_STOP: r_nco_en <= 1'b0;
                        c_OP_COMMIT: begin
                            r_nco_tw   <= r_staged_tw;
                            r_nco_load <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_LOAD: begin
                    if (bus.gen_ready) begin
                        r_nco_load  <= 1'b0;
                        r_active_tw <= r_staged_tw;
                        r_cnt       <= '0;
                    end
                end
                S_SETTLE: r_cnt <= r_cnt + 1'b1;
                S_ACK: begin
                    r_ack <= r_cmd_tog;
                    r_err <= r_cmd_err;
                end
                default: ;
            endcase
        end
    end

    assign bus.status_word   = {r_ack, r_busy, r_err, r_nco_en};
    assign bus.nco_tw        = r_nco_tw;
    assign bus.nco_tw_load   = r_nco_load;
    assign bus.nco_enable    = r_nco_en;
    assign bus.nco_phase_clr = w_phase_clr;

endmodule
`default_nettype wire

// File: tb/tb_freq_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_cmd_sequencer
//  Description : Directed self-checking bench for freq_cmd_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_cmd_sequencer;

    localparam int TW = 16;
    localparam int ST = 5;

    logic clk_clk = 1'b0;
    logic reset_reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic tog;
    int   lat, load_n, gaps, phase_n, busy_n;
    logic moved;

    freq_cmd_sequencer_if #(.TW_WIDTH(TW)) u_if ();

    freq_cmd_sequencer #(
        .TW_WIDTH      (TW),
        .SETTLE_CYCLES (ST)
    ) u_dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (u_if.slave)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (5) @(negedge clk_clk);
    endtask

    // Latency is counted in rising edges from the write until the ack is seen.
    task automatic run_cmd(input logic [31:0] w, input int ready_at, input int flip_at,
                           output int o_lat, output int o_load, output int o_gaps,
                           output int o_phase, output logic o_moved);
        logic [TW-1:0] tw0;
        tw0 = '0;
        o_lat = -1; o_load = 0; o_gaps = 0; o_phase = 0; o_moved = 1'b0;
        tog = ~tog;
        u_if.cmd_word = {tog, w[30:0]};
        if (ready_at > 0) u_if.gen_ready = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk_clk);
            if (k == ready_at) u_if.gen_ready = 1'b1;
            if (flip_at > 0 && (k == flip_at || k == flip_at + 1))
                u_if.cmd_word[31] = ~u_if.cmd_word[31];
            if (u_if.nco_tw_load) begin
                if (o_load == 0) tw0 = u_if.nco_tw;
                else if (u_if.nco_tw != tw0) o_moved = 1'b1;
                o_load++;
            end
            if (u_if.nco_phase_clr) o_phase++;
            if (u_if.status_word[3] == tog) begin
                o_lat = k;
                break;
            end
            if (k >= 2 && !u_if.status_word[2]) o_gaps++;
        end
    endtask

    task automatic count_busy(input int n, output int o_busy);
        o_busy = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk_clk);
            if (u_if.status_word[2] || u_if.nco_tw_load) o_busy++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tog = 1'b1;
        u_if.cmd_word  = 32'h8000_0000;
        u_if.gen_ready = 1'b1;
        do_reset();
        check_eq("reset_status", {28'd0, u_if.status_word}, 32'h8);
        check_eq("reset_enable", {31'd0, u_if.nco_enable}, 32'h0);
        check_eq("reset_tw", {16'd0, u_if.nco_tw}, 32'h0);
        check_eq("reset_load", {31'd0, u_if.nco_tw_load}, 32'h0);

        run_cmd(32'h1000_1234, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("settw_lat", lat, 4);
        check_eq("settw_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b000});

        run_cmd(32'h4000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("commit_lat", lat, ST + 5);
        check_eq("commit_load_cycles", load_n, 1);
        check_eq("commit_tw", {16'd0, u_if.nco_tw}, 32'h1234);
        check_eq("commit_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b000});

        run_cmd(32'h4000_0000, 13, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("stall_load_cycles", load_n, 11);
        check_eq("stall_tw_stable", {31'd0, moved}, 32'h0);
        check_eq("stall_busy_gaps", gaps, 0);
        check_eq("stall_lat", lat, ST + 15);

        do_reset();
        check_eq("reset2_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b000});
        check_eq("reset2_tw", {16'd0, u_if.nco_tw}, 32'h0);

        run_cmd(32'h2000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("start_noTW_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b010});
        run_cmd(32'h1000_0100, 0, 0, lat, load_n, gaps, phase_n, moved);
        run_cmd(32'h4000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        run_cmd(32'h2000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("start_ok_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b001});
        check_eq("start_ok_enable", {31'd0, u_if.nco_enable}, 32'h1);

        run_cmd(32'h7000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("illegal_op_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b011});
        run_cmd(32'h1000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("settw_zero_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b011});
        run_cmd(32'h1001_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("settw_wide_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b011});
        run_cmd(32'h4000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("staged_kept_tw", {16'd0, u_if.nco_tw}, 32'h0100);
        check_eq("staged_kept_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b001});

        run_cmd(32'h1000_2222, 0, 0, lat, load_n, gaps, phase_n, moved);
        run_cmd(32'h4000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("live_commit_tw", {16'd0, u_if.nco_tw}, 32'h2222);
        check_eq("live_commit_enable", {31'd0, u_if.nco_enable}, 32'h1);

        run_cmd(32'h5000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("phase_clr_pulses", phase_n, 1);
        check_eq("phase_clr_lat", lat, 4);

        run_cmd(32'h3000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("stop_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b000});
        check_eq("stop_tw", {16'd0, u_if.nco_tw}, 32'h2222);
        run_cmd(32'h3000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);
        check_eq("stop_again_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b000});
        run_cmd(32'h2000_0000, 0, 0, lat, load_n, gaps, phase_n, moved);

        run_cmd(32'h4000_0000, 0, 6, lat, load_n, gaps, phase_n, moved);
        check_eq("dflip_lat", lat, ST + 5);
        count_busy(10, busy_n);
        check_eq("dflip_no_replay", busy_n, 0);
        check_eq("dflip_status", {28'd0, u_if.status_word}, {28'd0, tog, 3'b001});

        tog = ~tog;
        u_if.cmd_word = {tog, 31'h4000_0000};
        repeat (6) @(negedge clk_clk);
        check_eq("midsettle_busy", {31'd0, u_if.status_word[2]}, 32'h1);
        reset_reset_n = 1'b0;
        repeat (2) @(negedge clk_clk);
        check_eq("midsettle_rst_load", {31'd0, u_if.nco_tw_load}, 32'h0);
        check_eq("midsettle_rst_enable", {31'd0, u_if.nco_enable}, 32'h0);
        check_eq("midsettle_rst_tw", {16'd0, u_if.nco_tw}, 32'h0);
        reset_reset_n = 1'b1;
        repeat (5) @(negedge clk_clk);
        check_eq("midsettle_baseline", {28'd0, u_if.status_word}, {28'd0, tog, 3'b000});
        count_busy(8, busy_n);
        check_eq("midsettle_no_replay", busy_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
